// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate arbiter.
package parking_pkg;

  localparam int unsigned DefaultCapacity = 8;

  typedef enum logic [1:0] {
    StIdle,
    StOpenIn,
    StOpenOut,
    StGuard
  } state_e;

  typedef enum logic {
    LaneEntry,
    LaneExit
  } lane_e;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter shared by the open timeout and the post-service guard delay.
module gate_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             done
);

  logic [Width-1:0] value;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - Width'(1);
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Arbitrates the single barrier gate between entry and exit lanes and tracks occupancy.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY   = DefaultCapacity,
  parameter int unsigned OPEN_TIME  = 16,
  parameter int unsigned GUARD_TIME = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           entry_req,
  input  logic                           exit_req,
  input  logic                           car_passed,
  output logic                           gate_open,
  output logic                           grant_entry,
  output logic                           grant_exit,
  output logic [$clog2(CAPACITY+1)-1:0]  count,
  output logic                           full,
  output logic                           empty,
  output logic                           timeout_err
);

  localparam int unsigned CountW  = $clog2(CAPACITY + 1);
  localparam int unsigned MaxTime = (OPEN_TIME > GUARD_TIME) ? OPEN_TIME : GUARD_TIME;
  localparam int unsigned TimerW  = $clog2(MaxTime + 1);

  state_e            state;
  lane_e             last_served;
  logic              elig_entry, elig_exit, pick_entry, pick_exit, open_done;
  logic              timer_load, timer_done;
  logic [TimerW-1:0] timer_val;

  assign full  = (count == CountW'(CAPACITY));
  assign empty = (count == '0);

  always_comb begin
    elig_entry = entry_req & ~full;
    elig_exit  = exit_req & ~empty;
    // On a tie, the lane that was not served last wins.
    pick_entry = elig_entry & (~elig_exit | (last_served == LaneExit));
    pick_exit  = elig_exit & ~pick_entry;
    open_done  = car_passed | timer_done;
    timer_load = 1'b0;
    timer_val  = TimerW'(GUARD_TIME - 1);
    case (state)
      StIdle: begin
        if (pick_entry || pick_exit) begin
          timer_load = 1'b1;
          timer_val  = TimerW'(OPEN_TIME - 1);
        end
      end
      StOpenIn, StOpenOut: timer_load = open_done;
      default: ;
    endcase
  end

  gate_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      last_served <= LaneExit;
      count       <= '0;
      gate_open   <= 1'b0;
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      grant_entry <= 1'b0;
      grant_exit  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        StIdle: begin
          if (pick_entry) begin
            state       <= StOpenIn;
            gate_open   <= 1'b1;
            grant_entry <= 1'b1;
            last_served <= LaneEntry;
          end else if (pick_exit) begin
            state       <= StOpenOut;
            gate_open   <= 1'b1;
            grant_exit  <= 1'b1;
            last_served <= LaneExit;
          end
        end
        StOpenIn, StOpenOut: begin
          if (open_done) begin
            state     <= StGuard;
            gate_open <= 1'b0;
            // A pass on the timer's last cycle still counts; saturate at the bounds.
            if (car_passed) begin
              if (state == StOpenIn && !full) begin
                count <= count + CountW'(1);
              end else if (state == StOpenOut && !empty) begin
                count <= count - CountW'(1);
              end
            end else begin
              timeout_err <= 1'b1;
            end
          end
        end
        StGuard: begin
          if (timer_done) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

- Shares the lot's single barrier gate between the entry lane and the exit lane.
- Tracks the occupancy count.
- Opens the gate for one car at a time, waits for the pass sensor or a timeout, then closes and re-arbitrates.
- Sits between the lane request/sensor inputs and the gate actuator/display logic of the parking system.

## Interface
- CAPACITY, 8: lot size in cars; entry refused when count == CAPACITY.
- OPEN_TIME, 16: max cycles the gate stays open waiting for car_passed.
- GUARD_TIME, 2: cycles the gate stays closed after each service before the next grant.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- entry_req  in  1  level: car waiting at entry lane.
- exit_req  in  1  level: car waiting at exit lane.
- car_passed  in  1  one-cycle pulse from gate sensor: car cleared the gate.
- gate_open  out  1  barrier actuator; 1 = open.
- grant_entry  out  1  one-cycle pulse on the first cycle the gate opens for entry.
- grant_exit  out  1  one-cycle pulse on the first cycle the gate opens for exit.
- count  out  $clog2(CAPACITY+1)  cars currently inside.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- timeout_err  out  1  one-cycle pulse when OPEN_TIME expires without car_passed.

## Operation
- States: IDLE, OPEN_IN, OPEN_OUT, GUARD.
- Request qualification:
  - eligible entry = entry_req & ~full.
  - eligible exit = exit_req & ~empty.
- IDLE arbitration:
  - Only one eligible -> grant it.
  - Both eligible -> round-robin via last_served flop; the lane not served last wins.
  - Grant moves the state to OPEN_IN or OPEN_OUT.
- OPEN_IN / OPEN_OUT:
  - gate_open=1 and the timer loads OPEN_TIME.
  - car_passed -> count ±1 (entry +1, exit -1), go to GUARD.
  - Timer reaching 0 without car_passed -> timeout_err pulse, count unchanged, go to GUARD.
  - last_served updates on entering OPEN_*, whether or not the car passes.
- GUARD: gate_open=0, wait GUARD_TIME cycles, then IDLE.
- Count never overflows or underflows:
  - eligibility rules prevent over/underflow by construction.
  - A car_passed arriving at a bound is ignored, with saturation as a safety net.
- full and empty are combinational decodes of the registered count.

## Timing
- Reset values:
  - state=IDLE, count=0, gate_open=0, grant_entry=0, grant_exit=0, timeout_err=0.
  - full=0, empty=1.
  - last_served=exit, so the first tie goes to entry.
- Latency: request sampled high in IDLE at edge N -> gate_open=1 and grant pulse during cycle N+1.
- car_passed sampled at edge M while OPEN_* -> count updated and gate_open=0 from cycle M+1.
- Gate stays open at most OPEN_TIME cycles.
- timeout_err asserts in the cycle after the last open cycle, together with gate_open falling.
- car_passed in the same cycle the timer expires: pass wins, count updates, no timeout_err.
- car_passed in IDLE or GUARD: ignored.
- Request dropped while OPEN_*: no effect; the gate still waits for pass/timeout.
- Minimum service period: 1 open cycle + GUARD_TIME closed cycles.
- A request held continuously is re-arbitrated at the GUARD -> IDLE transition. It is granted in the first IDLE cycle after GUARD with no idle gap beyond that single cycle.
- Reset asserted mid-operation:
  - gate_open drops asynchronously and count clears; any pending pass is lost.
  - On deassertion the first arbitration occurs at the first clk edge.

## Structure
- Shared package parking_pkg:
  - state enum (IDLE, OPEN_IN, OPEN_OUT, GUARD).
  - lane enum (LANE_ENTRY, LANE_EXIT) for last_served.
  - default CAPACITY.
- Sub-module gate_timer:
  - loadable down-counter, width $clog2(max(OPEN_TIME,GUARD_TIME)+1).
  - ports: load, load_val, done.
  - reused for both the open timeout and the guard delay.

## Test plan
- Reset, entry_req=1 held with CAPACITY=8 -> grant_entry pulse 1 cycle after reset release, then car_passed -> count=1, gate_open=0 next cycle, GUARD 2 cycles, second grant_entry.
- entry_req and exit_req both high with count=3 -> first grant entry (count 4). The next service is exit (count 3), and grants alternate entry/exit thereafter.
- count=8 (full), entry_req=1, exit_req=0 -> no grant ever, gate_open stays 0. Raising exit_req -> grant_exit, and count becomes 7 after the pass.
- Grant with no car_passed -> gate_open high exactly 16 cycles, timeout_err pulse, count unchanged.
- car_passed coincident with the timer's final cycle -> count updates and timeout_err stays 0.
- reset pulled low while OPEN_IN with count=5 -> gate_open=0 and count=0 immediately. After release, empty=1 and exit_req alone produces no grant.
